// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, latency and legality check.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_SLL = 5'b00010,
        ALU_XOR = 5'b00101,
        ALU_SRL = 5'b00110,
        ALU_SRA = 5'b00111,
        ALU_OR  = 5'b01000,
        ALU_AND = 5'b01001
    } alu_op_e;

    localparam int ALU_LATENCY = 1;

    function automatic logic op_legal(input logic [4:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR,
            ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arb_rsp_slot.sv
// One-entry result buffer with valid/ready handshake; a fill in the same
// cycle as a pop wins and keeps the slot valid with the new result.
module rsp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              fill_err,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic              err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else if (fill) begin
            valid_reg <= 1'b1;
            data_reg  <= fill_data;
            err_reg   <= fill_err;
        end else if (valid_reg && rsp_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = valid_reg;
    assign rsp_data  = data_reg;
    assign rsp_err   = err_reg;

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin time-sharing of one registered ALU between two requesters,
// with in-flight tracking and a per-port response slot.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [4:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [4:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic [4:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result
);

    logic [1:0]        req_valid;
    logic [1:0]        rsp_ready;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_err;
    logic [4:0]        req_op   [2];
    logic [DATA_W-1:0] req_a    [2];
    logic [DATA_W-1:0] req_b    [2];
    logic [DATA_W-1:0] rsp_data [2];

    logic [1:0] elig;
    logic [1:0] grant;
    logic       grant_id;
    logic [1:0] fill;

    logic inflight_v_reg;
    logic inflight_id_reg;
    logic inflight_err_reg;
    logic last_grant_reg;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            // A port with a result still in the ALU may not issue again.
            assign elig[gi] = !rst && req_valid[gi]
                              && (!rsp_valid[gi] || rsp_ready[gi])
                              && !(inflight_v_reg && (inflight_id_reg == 1'(gi)));
            assign fill[gi] = inflight_v_reg && (inflight_id_reg == 1'(gi));

            rsp_slot #(.DATA_W(DATA_W)) u_slot (
                .clk       (clk),
                .rst       (rst),
                .fill      (fill[gi]),
                .fill_data (alu_result),
                .fill_err  (inflight_err_reg),
                .rsp_ready (rsp_ready[gi]),
                .rsp_valid (rsp_valid[gi]),
                .rsp_data  (rsp_data[gi]),
                .rsp_err   (rsp_err[gi])
            );
        end
    endgenerate

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_grant_reg ? 2'b01 : 2'b10;
        end
    end

    assign grant_id = grant[1];

    always_comb begin
        alu_op = 5'b00000;
        alu_a  = '0;
        alu_b  = '0;
        if (grant != 2'b00) begin
            alu_op = req_op[grant_id];
            alu_a  = req_a[grant_id];
            alu_b  = req_b[grant_id];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_v_reg   <= 1'b0;
            inflight_id_reg  <= 1'b0;
            inflight_err_reg <= 1'b0;
            last_grant_reg   <= 1'b1;
        end else begin
            inflight_v_reg <= (grant != 2'b00);
            if (grant != 2'b00) begin
                inflight_id_reg  <= grant_id;
                inflight_err_reg <= !op_legal(req_op[grant_id]);
                last_grant_reg   <= grant_id;
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = rsp_data[0];
    assign rsp1_data  = rsp_data[1];
    assign rsp0_err   = rsp_err[0];
    assign rsp1_err   = rsp_err[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: registered ALU model, cycle-level behavioural
// reference, directed scenarios and randomized traffic.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [4:0]  req_op [2];
    logic [31:0] req_a  [2];
    logic [31:0] req_b  [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_data [2];
    logic [1:0]  rsp_err;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req_valid[0]),
        .req0_ready (req_ready[0]),
        .req0_op    (req_op[0]),
        .req0_a     (req_a[0]),
        .req0_b     (req_b[0]),
        .req1_valid (req_valid[1]),
        .req1_ready (req_ready[1]),
        .req1_op    (req_op[1]),
        .req1_a     (req_a[1]),
        .req1_b     (req_b[1]),
        .rsp0_valid (rsp_valid[0]),
        .rsp0_ready (rsp_ready[0]),
        .rsp0_data  (rsp_data[0]),
        .rsp0_err   (rsp_err[0]),
        .rsp1_valid (rsp_valid[1]),
        .rsp1_ready (rsp_ready[1]),
        .rsp1_data  (rsp_data[1]),
        .rsp1_err   (rsp_err[1]),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'b00001: return a - b;
            5'b00010: return a << b[4:0];
            5'b00101: return a ^ b;
            5'b00110: return a >> b[4:0];
            5'b00111: return 32'($signed(a) >>> b[4:0]);
            5'b01000: return a | b;
            5'b01001: return a & b;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return op inside {5'b00000, 5'b00001, 5'b00010, 5'b00101,
                          5'b00110, 5'b00111, 5'b01000, 5'b01001};
    endfunction

    // Environment ALU: one-cycle registered result.
    always @(posedge clk) alu_result <= alu_ref(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: what each port's slot holds and what is inside the ALU.
    logic        m_slot_v [2];
    logic [31:0] m_slot_d [2];
    logic        m_slot_e [2];
    logic        m_if_v;
    int          m_if_port;
    logic [31:0] m_if_res;
    logic        m_if_err;
    int          m_last;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_slot_v[p] = 1'b0;
            m_slot_d[p] = '0;
            m_slot_e[p] = 1'b0;
        end
        m_if_v    = 1'b0;
        m_if_port = 0;
        m_if_res  = '0;
        m_if_err  = 1'b0;
        m_last    = 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_rsp0_data", rsp_data[0], 32'd0);
                chk("rst_rsp1_data", rsp_data[1], 32'd0);
                chk("rst_rsp_err", 32'(rsp_err), 32'd0);
                chk("rst_alu_op", 32'(alu_op), 32'd0);
                chk("rst_alu_ab", alu_a | alu_b, 32'd0);
                model_reset();
            end else begin
                bit elig [2];
                int win;
                for (int p = 0; p < 2; p++) begin
                    elig[p] = req_valid[p] && (!m_slot_v[p] || rsp_ready[p]) && !(m_if_v && m_if_port == p);
                end
                if (elig[0] && elig[1]) win = 1 - m_last;
                else if (elig[0])       win = 0;
                else if (elig[1])       win = 1;
                else                    win = -1;

                chk("req0_ready", 32'(req_ready[0]), 32'(win == 0));
                chk("req1_ready", 32'(req_ready[1]), 32'(win == 1));
                chk("alu_op", 32'(alu_op), (win >= 0) ? 32'(req_op[win]) : 32'd0);
                chk("alu_a", alu_a, (win >= 0) ? req_a[win] : 32'd0);
                chk("alu_b", alu_b, (win >= 0) ? req_b[win] : 32'd0);
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("rsp%0d_valid", p), 32'(rsp_valid[p]), 32'(m_slot_v[p]));
                    if (m_slot_v[p]) begin
                        chk($sformatf("rsp%0d_data", p), rsp_data[p], m_slot_d[p]);
                        chk($sformatf("rsp%0d_err", p), 32'(rsp_err[p]), 32'(m_slot_e[p]));
                    end
                end

                for (int p = 0; p < 2; p++) begin
                    if (m_if_v && m_if_port == p) begin
                        m_slot_v[p] = 1'b1;
                        m_slot_d[p] = m_if_res;
                        m_slot_e[p] = m_if_err;
                    end else if (m_slot_v[p] && rsp_ready[p]) begin
                        m_slot_v[p] = 1'b0;
                    end
                end
                m_if_v = (win >= 0);
                if (win >= 0) begin
                    m_if_port = win;
                    m_if_res  = alu_ref(req_op[win], req_a[win], req_b[win]);
                    m_if_err  = !is_legal(req_op[win]);
                    m_last    = win;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[p] = 1'b1;
        req_op[p]    = op;
        req_a[p]     = a;
        req_b[p]     = b;
    endtask

    // Lone single-cycle request on port p; response expected two cycles later.
    task automatic issue_one(input int p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_d, input logic exp_e, input string name);
        req_valid    = '0;
        rsp_ready[p] = 1'b1;
        repeat (3) @(negedge clk);
        set_req(p, op, a, b);
        #1 chk({name, "_ready"}, 32'(req_ready[p]), 32'd1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk({name, "_valid"}, 32'(rsp_valid[p]), 32'd1);
        chk({name, "_data"}, rsp_data[p], exp_d);
        chk({name, "_err"}, 32'(rsp_err[p]), 32'(exp_e));
    endtask

    logic [4:0] legal_ops [8];
    int p0_grants;

    initial begin
        legal_ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001};
        for (int p = 0; p < 2; p++) begin
            req_op[p] = '0;
            req_a[p]  = '0;
            req_b[p]  = '0;
        end

        // Single add on port 0.
        do_reset();
        rsp_ready = 2'b11;
        set_req(0, 5'b00000, 32'd5, 32'd7);
        #1 chk("add_req0_ready", 32'(req_ready[0]), 32'd1);
        chk("add_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        req_valid = '0;
        #1 chk("add_rsp0_early", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        #1;
        chk("add_rsp0_valid", 32'(rsp_valid[0]), 32'd1);
        chk("add_rsp0_data", rsp_data[0], 32'd12);
        chk("add_rsp0_err", 32'(rsp_err[0]), 32'd0);

        // Both ports streaming: grants alternate starting with port 0.
        do_reset();
        set_req(0, 5'b00001, 32'd10, 32'd3);
        set_req(1, 5'b00101, 32'h0000_00F0, 32'h0000_000F);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("alt_req0_c%0d", i), 32'(req_ready[0]), 32'(i % 2 == 0));
            chk($sformatf("alt_req1_c%0d", i), 32'(req_ready[1]), 32'(i % 2 == 1));
            if (i == 2) chk("alt_rsp0_data", rsp_data[0], 32'd7);
            if (i == 3) chk("alt_rsp1_data", rsp_data[1], 32'h0000_00FF);
            @(negedge clk);
        end

        // Port 1 backpressured: its slot holds, port 0 keeps issuing.
        rsp_ready[1] = 1'b0;
        p0_grants    = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i >= 3) begin
                chk($sformatf("bp_req1_c%0d", i), 32'(req_ready[1]), 32'd0);
                chk($sformatf("bp_rsp1_valid_c%0d", i), 32'(rsp_valid[1]), 32'd1);
                chk($sformatf("bp_rsp1_data_c%0d", i), rsp_data[1], 32'h0000_00FF);
                p0_grants += int'(req_ready[0]);
            end
            @(negedge clk);
        end
        chk("bp_p0_grants", 32'(p0_grants), 32'd2);
        rsp_ready[1] = 1'b1;
        #1 chk("bp_release_req1", 32'(req_ready[1]), 32'd1);
        @(negedge clk);

        // Illegal op and shift corners.
        issue_one(1, 5'b00011, 32'd2, 32'd3, 32'd5, 1'b1, "illegal");
        issue_one(0, 5'b00111, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, "sra");
        issue_one(0, 5'b00010, 32'd1, 32'd33, 32'd2, 1'b0, "sll");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                req_valid[p] = ($urandom_range(0, 3) != 0);
                req_op[p]    = ($urandom_range(0, 5) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 7)];
                req_a[p]     = $urandom;
                req_b[p]     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                rsp_ready[p] = ($urandom_range(0, 2) != 0);
            end
        end

        // Reset the cycle after an issue: the result must be discarded.
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (3) @(negedge clk);
        set_req(0, 5'b00000, 32'd1, 32'd1);
        #1 chk("rst_issue_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b1;
        #1 chk("rst_mid_rsp0", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_hold_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_hold_data", rsp_data[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 5'b00000, 32'd3, 32'd4);
        set_req(1, 5'b00000, 32'd5, 32'd6);
        #1;
        chk("post_rst_tie_req0", 32'(req_ready[0]), 32'd1);
        chk("post_rst_tie_req1", 32'(req_ready[1]), 32'd0);
        chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        repeat (4) @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
